controle_desvios: RTL

- Next-PC generator that closes the loop around the program counter register.
- Consumes the current PC (SaidaPC) and decoded control requests. Produces the already-incremented next address (EntradaPC) plus the NopFlag and BreakFlag controls that the PC register obeys.
- Sequences multi-cycle NOP stalls and a break/halt state, and captures a link (return) address for jump-and-link.

---
 rtl/controle_desvios.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/controle_desvios.sv
// Next-PC generator: sequential, branch, jump(-and-link), NOP stall and break/halt control.
// Latency: EntradaPC and all flags are combinational (zero cycles); state, stall counter and LinkAddr are registered.
// Backpressure: no handshake; the PC register is held via NopFlag while stalled or halted.
module controle_desvios #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PC_STEP = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SaidaPC,
  input  logic             BranchReq,
  input  logic             CondFlag,
  input  logic [WIDTH-1:0] BranchOffset,
  input  logic             JumpReq,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             LinkReq,
  input  logic             NopReq,
  input  logic [CNT_W-1:0] NopCycles,
  input  logic             BreakReq,
  input  logic             Resume,
  output logic [WIDTH-1:0] EntradaPC,
  output logic             NopFlag,
  output logic             BreakFlag,
  output logic             Flush,
  output logic             Halted,
  output logic [WIDTH-1:0] LinkAddr
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] link_q, link_d;

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] next_pc;
  logic             nop_flag;
  logic             brk_flag;
  logic             flush_flag;

  // Sequential address and branch target; both wrap modulo 2^WIDTH.
  assign pc_inc    = SaidaPC + WIDTH'(PC_STEP);
  assign br_target = pc_inc + BranchOffset;

  // Next-state, next-PC and flag decode, priority ordered within each state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    link_d     = link_q;
    next_pc    = pc_inc;
    nop_flag   = 1'b0;
    brk_flag   = 1'b0;
    flush_flag = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (BreakReq) begin
          brk_flag = 1'b1;
          next_pc  = '0;
          state_d  = ST_HALT;
        end else if (NopReq) begin
          nop_flag = 1'b1;
          next_pc  = SaidaPC;
          // This cycle is the first stall cycle; the counter holds the rest.
          if (NopCycles > CNT_W'(1)) begin
            state_d = ST_STALL;
            cnt_d   = NopCycles - CNT_W'(1);
          end
        end else if (JumpReq) begin
          next_pc    = JumpTarget;
          flush_flag = 1'b1;
          if (LinkReq) begin
            link_d = pc_inc;
          end
        end else if (BranchReq && CondFlag) begin
          next_pc    = br_target;
          flush_flag = 1'b1;
        end
      end
      ST_STALL: begin
        if (BreakReq) begin
          brk_flag = 1'b1;
          next_pc  = '0;
          cnt_d    = '0;
          state_d  = ST_HALT;
        end else begin
          nop_flag = 1'b1;
          next_pc  = SaidaPC;
          // A counter of 0 cannot occur in STALL; treat it as the last cycle.
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_HALT: begin
        nop_flag = 1'b1;
        next_pc  = SaidaPC;
        if (Resume) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
    endcase
  end

  // State, stall counter and link register.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      link_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      link_q  <= link_d;
    end
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    EntradaPC = Reset ? next_pc : '0;
    NopFlag   = Reset & nop_flag;
    BreakFlag = Reset & brk_flag;
    Flush     = Reset & flush_flag;
    Halted    = Reset & (state_q == ST_HALT);
    LinkAddr  = link_q;
  end

endmodule
